// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Shares one single-port on-chip RAM between two Avalon-MM requesters
// (m0 = CPU data master, m1 = DMA/stream master).
//
// Each cycle at most one access is granted. When both masters request at
// once, the winner is picked round-robin. The granted master's address,
// byteenable, write and writedata are steered onto the RAM. Reads are tracked
// through a READ_LATENCY-deep pipeline, so the RAM's data can be returned to
// the right master with readdatavalid.
//
// Parameters
//   ADDR_W        word-address width of the RAM
//   DATA_W        data width (byteenable is DATA_W/8 bits)
//   READ_LATENCY  cycles from the address cycle to valid mem_readdata
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   mN_address/byteenable/read/write/writedata
//                                 requester N command inputs (N = 0, 1)
//   mN_waitrequest                high = requester N not accepted this cycle
//   mN_readdata/readdatavalid     read return to requester N
//   mem_address/byteenable/chipselect/write/writedata/clken
//                                 RAM command outputs
//   mem_readdata                  RAM read data
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic                    req0;
    logic                    req1;
    logic                    grant0;
    logic                    grant1;
    logic                    rd_accept;
    logic                    prio;
    logic [READ_LATENCY-1:0] rd_vld_p;
    logic [READ_LATENCY-1:0] rd_own_p;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // No grant while reset is held, so the RAM sees no traffic and the
    // forced-high waitrequests agree with what actually reaches the memory.
    assign grant0 = ~reset & req0 & (~req1 | ~prio);
    assign grant1 = ~reset & req1 & (~req0 |  prio);

    assign m0_waitrequest = reset | (req0 & ~grant0);
    assign m1_waitrequest = reset | (req1 & ~grant1);

    // A simultaneous read+write is treated as a write only.
    assign rd_accept = (grant0 & m0_read & ~m0_write) |
                       (grant1 & m1_read & ~m1_write);

    // Address-cycle stage: steer the granted master onto the RAM.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end else if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end
    end

    assign mem_chipselect = grant0 | grant1;
    assign mem_clken      = ~reset;

    // Control state: priority and read-tracking valids clear asynchronously,
    // which drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio     <= 1'b0;
            rd_vld_p <= '0;
        end else begin
            // With both requesting, the loser is favoured next time.
            if (req0 && req1)
                prio <= ~prio;
            rd_vld_p[0] <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++)
                rd_vld_p[i] <= rd_vld_p[i-1];
        end
    end

    // Owner tags only matter when qualified by their valid bit.
    always_ff @(posedge clk) begin
        rd_own_p[0] <= grant1;
        for (int i = 1; i < READ_LATENCY; i++)
            rd_own_p[i] <= rd_own_p[i-1];
    end

    // Return stage: the last tracking entry selects which master sees valid.
    assign m0_readdatavalid = rd_vld_p[READ_LATENCY-1] & ~rd_own_p[READ_LATENCY-1];
    assign m1_readdatavalid = rd_vld_p[READ_LATENCY-1] &  rd_own_p[READ_LATENCY-1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
//
// Two arbiters share identical master stimulus: dut_a with READ_LATENCY=1
// driving a RAM with unregistered output, dut_b with READ_LATENCY=2 driving a
// RAM with registered output. A behavioural model (ideal memory array,
// round-robin "next favoured" flag, and queues of due read returns) is
// compared with both DUTs on every falling edge. Directed sequences add
// literal expectations; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          rd [2];
    logic          wr [2];
    logic [AW-1:0] ad [2];
    logic [BW-1:0] be [2];
    logic [DW-1:0] wd [2];

    logic          a_wt0, a_wt1, a_rdv0, a_rdv1, a_cs, a_we, a_ck;
    logic [DW-1:0] a_rd0, a_rd1, a_wd, a_q;
    logic [AW-1:0] a_addr;
    logic [BW-1:0] a_be;
    logic          b_wt0, b_wt1, b_rdv0, b_rdv1, b_cs, b_we, b_ck;
    logic [DW-1:0] b_rd0, b_rd1, b_wd, b_q;
    logic [AW-1:0] b_addr;
    logic [BW-1:0] b_be;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .m0_address(ad[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
        .m0_writedata(wd[0]), .m0_waitrequest(a_wt0), .m0_readdata(a_rd0),
        .m0_readdatavalid(a_rdv0),
        .m1_address(ad[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
        .m1_writedata(wd[1]), .m1_waitrequest(a_wt1), .m1_readdata(a_rd1),
        .m1_readdatavalid(a_rdv1),
        .mem_address(a_addr), .mem_byteenable(a_be), .mem_chipselect(a_cs),
        .mem_write(a_we), .mem_writedata(a_wd), .mem_clken(a_ck), .mem_readdata(a_q)
    );

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset),
        .m0_address(ad[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
        .m0_writedata(wd[0]), .m0_waitrequest(b_wt0), .m0_readdata(b_rd0),
        .m0_readdatavalid(b_rdv0),
        .m1_address(ad[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
        .m1_writedata(wd[1]), .m1_waitrequest(b_wt1), .m1_readdata(b_rd1),
        .m1_readdatavalid(b_rdv1),
        .mem_address(b_addr), .mem_byteenable(b_be), .mem_chipselect(b_cs),
        .mem_write(b_we), .mem_writedata(b_wd), .mem_clken(b_ck), .mem_readdata(b_q)
    );

    // RAM behind dut_a: one cycle of read latency.
    logic [DW-1:0] ram_a [0:8191];
    always @(posedge clk) begin
        if (a_ck && a_cs) begin
            if (a_we) begin
                for (int b = 0; b < BW; b++)
                    if (a_be[b]) ram_a[a_addr][8*b +: 8] <= a_wd[8*b +: 8];
            end else begin
                a_q <= ram_a[a_addr];
            end
        end
    end

    // RAM behind dut_b: extra output register, two cycles of read latency.
    logic [DW-1:0] ram_b [0:8191];
    logic [DW-1:0] qb1;
    always @(posedge clk) begin
        if (b_ck) begin
            b_q <= qb1;
            if (b_cs) begin
                if (b_we) begin
                    for (int b = 0; b < BW; b++)
                        if (b_be[b]) ram_b[b_addr][8*b +: 8] <= b_wd[8*b +: 8];
                end else begin
                    qb1 <= ram_b[b_addr];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        bit          own;
        logic [31:0] data;
    } ret_t;

    ret_t        qa [$];
    ret_t        qb [$];
    logic [31:0] mm [0:8191];
    int          fav = 0;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
            mm[i]    = '0;
        end
        a_q = '0;
        qb1 = '0;
        b_q = '0;
    end

    always @(negedge clk) begin : model
        int          w;
        bit          r0, r1, ev0a, ev1a, ev0b, ev1b;
        logic [31:0] eda, edb;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        logic [DW-1:0] ed;
        bit          ewe;
        cyc++;
        r0 = rd[0] | wr[0];
        r1 = rd[1] | wr[1];
        if (reset) begin
            fav = 0;
            qa.delete();
            qb.delete();
            chk("rst_wait0_a", a_wt0, 1);  chk("rst_wait1_a", a_wt1, 1);
            chk("rst_wait0_b", b_wt0, 1);  chk("rst_wait1_b", b_wt1, 1);
            chk("rst_rdv_a", {a_rdv0, a_rdv1}, 0);
            chk("rst_rdv_b", {b_rdv0, b_rdv1}, 0);
            chk("rst_clken_a", a_ck, 0);   chk("rst_clken_b", b_ck, 0);
        end else begin
            w = -1;
            if (r0 && r1)  w = fav;
            else if (r0)   w = 0;
            else if (r1)   w = 1;

            chk("wait0_a", a_wt0, r0 && (w != 0));
            chk("wait1_a", a_wt1, r1 && (w != 1));
            chk("wait0_b", b_wt0, r0 && (w != 0));
            chk("wait1_b", b_wt1, r1 && (w != 1));

            ea = '0; eb = '0; ed = '0; ewe = 0;
            if (w >= 0) begin
                ea = ad[w]; eb = be[w]; ed = wd[w]; ewe = wr[w];
            end
            chk("mem_cmd_a", {a_ck, a_cs, a_we, a_be, a_addr}, {1'b1, w >= 0, ewe, eb, ea});
            chk("mem_wdata_a", a_wd, ed);
            chk("mem_cmd_b", {b_ck, b_cs, b_we, b_be, b_addr}, {1'b1, w >= 0, ewe, eb, ea});
            chk("mem_wdata_b", b_wd, ed);

            ev0a = 0; ev1a = 0; eda = '0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                if (qa[0].own) ev1a = 1; else ev0a = 1;
                eda = qa[0].data;
                void'(qa.pop_front());
            end
            ev0b = 0; ev1b = 0; edb = '0;
            if (qb.size() > 0 && qb[0].due == cyc) begin
                if (qb[0].own) ev1b = 1; else ev0b = 1;
                edb = qb[0].data;
                void'(qb.pop_front());
            end
            chk("rdv0_a", a_rdv0, ev0a);  chk("rdv1_a", a_rdv1, ev1a);
            chk("rdv0_b", b_rdv0, ev0b);  chk("rdv1_b", b_rdv1, ev1b);
            if (ev0a) chk("rdata0_a", a_rd0, eda);
            if (ev1a) chk("rdata1_a", a_rd1, eda);
            if (ev0b) chk("rdata0_b", b_rd0, edb);
            if (ev1b) chk("rdata1_b", b_rd1, edb);

            if (w >= 0) begin
                if (wr[w]) begin
                    for (int b = 0; b < BW; b++)
                        if (be[w][b]) mm[ad[w]][8*b +: 8] = wd[w][8*b +: 8];
                end else if (rd[w]) begin
                    qa.push_back('{due: cyc + 1, own: w[0], data: mm[ad[w]]});
                    qb.push_back('{due: cyc + 2, own: w[0], data: mm[ad[w]]});
                end
                if (r0 && r1) fav = (w == 0) ? 1 : 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int m, input bit r, input bit w_, input logic [AW-1:0] a,
                       input logic [BW-1:0] b, input logic [DW-1:0] d);
        rd[m] = r; wr[m] = w_; ad[m] = a; be[m] = b; wd[m] = d;
    endtask

    task automatic idle(input int m);
        drv(m, 0, 0, '0, '0, '0);
    endtask

    initial begin
        bit acc [2];
        int k;
        idle(0);
        idle(1);
        reset = 1;
        repeat (3) tick();
        reset = 0;

        // m0 write then read-back
        drv(0, 0, 1, 13'h0010, 4'hF, 32'hDEADBEEF);
        #1 chk("t1_wr_wait", a_wt0, 0);
        tick();
        drv(0, 1, 0, 13'h0010, 4'hF, 32'h0);
        #1 chk("t1_rd_wait", a_wt0, 0);
        tick();
        idle(0);
        #1 chk("t1_rdv_a", a_rdv0, 1);
        chk("t1_data_a", a_rd0, 32'hDEADBEEF);
        chk("t1_rdv1_a", a_rdv1, 0);
        tick();
        chk("t1_rdv_b", b_rdv0, 1);
        chk("t1_data_b", b_rd0, 32'hDEADBEEF);
        chk("t1_rdv1_b", b_rdv1, 0);

        // preload two words, then continuous contention from reset
        drv(0, 0, 1, 13'h0001, 4'hF, 32'h11111111);
        drv(1, 0, 1, 13'h0002, 4'hF, 32'h22222222);
        repeat (2) tick();
        idle(0); idle(1);
        reset = 1;
        repeat (2) tick();
        reset = 0;
        drv(0, 1, 0, 13'h0001, 4'hF, 32'h0);
        drv(1, 1, 0, 13'h0002, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_wait0", a_wt0, i % 2);
            chk("t2_wait1", a_wt1, 1 - (i % 2));
            if (i > 0) begin
                chk("t2_rdv0", a_rdv0, i % 2);
                chk("t2_rdv1", a_rdv1, 1 - (i % 2));
                if (i % 2) chk("t2_data0", a_rd0, 32'h11111111);
                else       chk("t2_data1", a_rd1, 32'h22222222);
            end
            tick();
        end
        idle(0); idle(1);
        tick();

        // byte-lane write at top of range
        drv(0, 0, 1, 13'h1FFF, 4'hF, 32'hCAFEF00D);
        tick();
        idle(0);
        drv(1, 0, 1, 13'h1FFF, 4'h1, 32'h000000AA);
        tick();
        idle(1);
        drv(0, 1, 0, 13'h1FFF, 4'hF, 32'h0);
        #1 chk("t3_addr", a_addr, 13'h1FFF);
        tick();
        idle(0);
        #1 chk("t3_rdv", a_rdv0, 1);
        chk("t3_data", a_rd0, 32'hCAFEF0AA);

        // same-cycle write (m0) and read (m1) of one address
        reset = 1;
        tick();
        reset = 0;
        drv(0, 0, 1, 13'h0020, 4'hF, 32'h12345678);
        drv(1, 1, 0, 13'h0020, 4'hF, 32'h0);
        #1 chk("t4_wait0", a_wt0, 0);
        chk("t4_wait1", a_wt1, 1);
        tick();
        idle(0);
        #1 chk("t4_wait1_next", a_wt1, 0);
        tick();
        idle(1);
        #1 chk("t4_rdv1", a_rdv1, 1);
        chk("t4_data1", a_rd1, 32'h12345678);

        // reset while an m1 read is in flight in the latency-2 arbiter
        tick();
        drv(1, 1, 0, 13'h0020, 4'hF, 32'h0);
        tick();
        idle(1);
        reset = 1;
        drv(0, 0, 1, 13'h0040, 4'hF, 32'h00000040);
        drv(1, 0, 1, 13'h0041, 4'hF, 32'h00000041);
        #1 chk("t5_rdv1_a", a_rdv1, 0);
        chk("t5_rdv1_b", b_rdv1, 0);
        chk("t5_wait_b", {b_wt0, b_wt1}, 2'b11);
        chk("t5_clken_b", b_ck, 0);
        tick();
        chk("t5_rdv1_b_late", b_rdv1, 0);
        tick();
        reset = 0;
        #1 chk("t5_wait0_after", b_wt0, 0);
        chk("t5_wait1_after", b_wt1, 1);
        tick();
        tick();
        idle(0); idle(1);

        // read and write together: write wins, no return
        drv(0, 1, 1, 13'h0030, 4'hF, 32'h00000055);
        #1 chk("t6_wait", a_wt0, 0);
        tick();
        idle(0);
        #1 chk("t6_no_rdv_a", a_rdv0, 0);
        tick();
        chk("t6_no_rdv_b", b_rdv0, 0);
        drv(0, 1, 0, 13'h0030, 4'hF, 32'h0);
        tick();
        idle(0);
        #1 chk("t6_rdv", a_rdv0, 1);
        chk("t6_data", a_rd0, 32'h00000055);
        tick();

        // randomized traffic obeying the hold-while-waitrequest rule
        acc[0] = 1; acc[1] = 1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int m = 0; m < 2; m++) begin
                if (acc[m] || !(rd[m] || wr[m])) begin
                    k = $urandom_range(0, 9);
                    rd[m] = (k >= 3 && k <= 5) || k == 9;
                    wr[m] = (k >= 6);
                    ad[m] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7))
                                                 : AW'(13'h1FF8 + $urandom_range(0, 7));
                    be[m] = BW'($urandom_range(0, 15));
                    wd[m] = $urandom;
                end
            end
            #3;
            acc[0] = (rd[0] || wr[0]) && !a_wt0;
            acc[1] = (rd[1] || wr[1]) && !a_wt1;
            tick();
        end
        reset = 0;
        idle(0); idle(1);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-port Avalon-MM arbiter that shares one single-port 8192x32 on-chip RAM between two requesters: m0 (CPU data master) and m1 (DMA/stream master).
- Grants one access per cycle using round-robin priority.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs.
- Returns read data to the owning requester with a fixed-latency readdatavalid.

Parameters:
- ADDR_W, 13, word-address width of the RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from the address cycle to valid mem_readdata (1 for unregistered RAM output, 2 for registered).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_byteenable  in  DATA_W/8  requester 0 byte lanes
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_writedata  in  DATA_W  requester 0 write data
- m0_waitrequest  out  1  high = m0 request not accepted this cycle
- m0_readdata  out  DATA_W  read data to m0
- m0_readdatavalid  out  1  m0_readdata valid
- m1_*  (same set as m0_*)  requester 1 ports
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM chipselect
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable, tied high except during reset
- mem_readdata  in  DATA_W  RAM read data

Behaviour:
- Request: reqN = mN_read | mN_write. If both mN_read and mN_write are high, the write wins and no readdatavalid is produced.
- Priority: register `prio` (0 = m0 favoured). Reset value 0.
- Grant is combinational:
  - Only one requester → it is granted.
  - Both requesters → the one selected by `prio` is granted.
  - Neither → no grant.
- After any cycle in which both requested, `prio` is set to the non-granted master. A single-requester grant leaves `prio` unchanged.
- Waitrequest: mN_waitrequest = reqN & ~grantN, forced high while reset is asserted. The accepted transfer is the cycle with reqN high and waitrequest low. The requester holds its signals while waitrequest is high (Avalon rule); the arbiter does not register requests.
- Memory mux (combinational):
  - mem_chipselect = any grant.
  - mem_address, mem_byteenable and mem_writedata come from the granted master, else all zeros.
  - mem_write = granted master's write.
- Read tracking: shift register of READ_LATENCY stages, each holding {valid, owner}.
  - Stage 0 loads {granted read & ~write, grant index}.
  - At the last stage, mN_readdatavalid = valid & (owner == N).
- Read data: mN_readdata = mem_readdata, unqualified; consumers qualify with readdatavalid.
- Throughput and latency:
  - One accepted access per cycle, fully pipelined reads.
  - Read latency from acceptance to readdatavalid = READ_LATENCY cycles.
  - Writes complete on the accept cycle.
- Read-after-write to the same address from either master, back to back: the read returns the new data (writes are issued in an earlier cycle).
- Reset, asynchronous and applied mid-operation:
  - Tracking register and `prio` clear immediately.
  - All readdatavalid outputs go low; in-flight reads are dropped and never returned.
  - mem_clken = ~reset.
  - Waitrequests are high.
- After reset deasserts, the arbiter accepts on the first clk edge.
- Starvation bound: a continuously requesting master waits at most 1 cycle.

Test Plan:
- After reset, m0 writes 0xDEADBEEF @0x0010 with be=0xF, then reads 0x0010 → waitrequest low both cycles; m0_readdatavalid high 1 cycle after the read accept with data 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously (m0 @0x0001, m1 @0x0002) for 6 cycles from reset → grants alternate m0,m1,m0,m1,m0,m1; each readdatavalid is high every other cycle with its own data; loser waitrequest=1 on alternate cycles.
- m1 writes 0x000000AA with be=0x1 @0x1FFF while m0 is idle, then m0 reads 0x1FFF → byte 0 = 0xAA and other bytes unchanged; address 0x1FFF (top of range) is passed intact.
- Same cycle: m0 write 0x12345678 @0x0020 and m1 read @0x0020, with prio=0 → m0 granted first; m1 read accepted next cycle and returns 0x12345678.
- Assert reset while an m1 read is in flight (READ_LATENCY=2 build) → no m1_readdatavalid pulse; waitrequests high during reset; prio=0 afterwards (m0 wins the first contention).
- m0 asserts read and write together @0x0030 with data 0x55 → write performed; no readdatavalid; a later read returns 0x55.
